cnt_window_ctrl: RTL and testbench
==================================

Name: cnt_window_ctrl

Overview:
- Sequencer for the team's 8-bit event counter (clk, rst_n, num_i, of, cnt[7:0]).
- Runs timed measurement windows on that counter:
  - clears it;
  - enables it for a programmed number of clock cycles;
  - captures count and overflow;
  - presents the result on a valid/ready handshake.
- Sits between a host/config interface and one counter instance. Supports single-shot and continuous (back-to-back) modes.

Parameters:
- WIN_W, 16, width of the window-length field in clock cycles.
- CNT_W, 8, width of the counter value being captured. Must match the counter.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start_i  input  1  level; sampled in IDLE to begin a measurement.
- cont_i  input  1  continuous mode. Sampled with start_i and held for the run.
- abort_i  input  1  cancels any run in progress.
- win_len_i  input  WIN_W  window length in cycles. Sampled with start_i.
- cnt_clr_o  output  1  synchronous clear to counter.
- cnt_en_o  output  1  count enable to counter (gates num_i upstream).
- cnt_i  input  CNT_W  counter value.
- of_i  input  1  counter overflow flag.
- busy_o  output  1  high in every state except IDLE.
- err_o  output  1  one-cycle pulse on a rejected start.
- res_valid_o  output  1  result available.
- res_ready_i  input  1  consumer accepts result.
- res_cnt_o  output  CNT_W  captured count.
- res_of_o  output  1  overflow occurred during the window.

Behaviour:
- Reset values: state IDLE; all outputs 0; internal timer, latched length/mode and sticky overflow 0.
- States: IDLE, CLEAR, COUNT, CAPTURE, RESULT. All outputs registered.
- IDLE:
  - start_i=1 with win_len_i!=0: latch win_len_i and cont_i, go to CLEAR.
  - start_i=1 with win_len_i==0: err_o=1 for one cycle, stay in IDLE.
- CLEAR (1 cycle): cnt_clr_o=1, cnt_en_o=0; load timer with the latched length; clear sticky overflow; go to COUNT.
- COUNT:
  - cnt_en_o=1 and timer decrements every cycle.
  - of_i=1 in any COUNT cycle sets sticky overflow.
  - On the cycle timer==1, go to CAPTURE. Enable is therefore high for exactly win_len cycles.
- CAPTURE (1 cycle): cnt_en_o=0. Register cnt_i into res_cnt_o and (sticky | of_i) into res_of_o. Go to RESULT.
- RESULT:
  - res_valid_o=1; res_cnt_o and res_of_o stay stable until the handshake.
  - Handshake is res_valid_o & res_ready_i. res_valid_o drops the next cycle.
  - After the handshake: latched cont=1 goes to CLEAR (the next window starts with no IDLE cycle); cont=0 goes to IDLE.
- Latency: start accept to res_valid_o = win_len + 3 cycles.
- abort_i:
  - In CLEAR, COUNT or CAPTURE: go to IDLE next cycle with cnt_en_o=0 and cnt_clr_o=1 for that one cycle. No result is produced.
  - In RESULT: res_valid_o drops and the result is discarded.
  - Takes priority over every other transition. Ignored in IDLE.
- start_i outside IDLE is ignored. win_len_i and cont_i changes during a run have no effect.
- Timer width is WIN_W. Maximum window is 2^WIN_W-1 cycles; no wrap inside a window.
- Async reset mid-run: immediate return to reset values; the counter is not cleared until the next CLEAR state.

Optional Feature:
- Macro: CNT_WINDOW_OVF_STOP_EN.
- Defined: the first of_i=1 in COUNT ends the window early. Next state is CAPTURE with cnt_en_o=0 from that cycle, and res_of_o=1.
- Undefined: the window always runs its full length and overflow is only recorded in the sticky flag.

Test Plan:
- Bench model: counter increments by 1 on each cnt_en_o cycle with num_i=1, clears on cnt_clr_o, and asserts of on a 255 to 0 wrap.
- Single shot: num_i=1, win_len=10, cont=0, res_ready=1 -> res_valid at start+13 cycles; res_cnt=10, res_of=0; busy_o=0 after the handshake.
- Overflow: num_i=1, win_len=300 ->
  - macro off: res_cnt=44, res_of=1.
  - macro on: capture after 256 enabled cycles, res_cnt=0, res_of=1.
- Continuous with backpressure: win_len=5, cont=1, res_ready held low 20 cycles then pulsed -> result held stable; next CLEAR on the cycle after the handshake; second result res_cnt=5.
- Abort: win_len=50, abort_i at cycle 20 of COUNT -> IDLE next cycle, one cnt_clr_o pulse, no res_valid.
- Rejects and reset: win_len=0 start -> err_o one-cycle pulse, stays IDLE; rst asserted mid-COUNT -> all outputs 0 immediately; fresh start afterwards runs normally.

Source files
------------

// File: rtl/cnt_window_ctrl.sv
// cnt_window_ctrl: runs timed measurement windows on an external CNT_W-bit
// event counter. Sequence: clear the counter, enable it for a programmed
// number of cycles, capture count and overflow, then offer the result on a
// valid/ready port. Supports single-shot and continuous (back-to-back) runs.
//
// Optional build macro CNT_WINDOW_OVF_STOP_EN: when defined, the first
// overflow seen during COUNT ends the window early. When undefined, the
// window always runs its full length and overflow is only recorded.
//
// Result handshake: res_valid_o rises when a result is captured and stays
// high, with res_cnt_o/res_of_o stable, until the cycle where
// res_valid_o & res_ready_i is sampled high; it drops on the next cycle.
// abort_i in RESULT also drops it and discards the result.
//
// state_o exposes the FSM state for debug and checkers
// (0 IDLE, 1 CLEAR, 2 COUNT, 3 CAPTURE, 4 RESULT).
module cnt_window_ctrl #(
  parameter int WIN_W = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             cont_i,
  input  logic             abort_i,
  input  logic [WIN_W-1:0] win_len_i,
  output logic             cnt_clr_o,
  output logic             cnt_en_o,
  input  logic [CNT_W-1:0] cnt_i,
  input  logic             of_i,
  output logic             busy_o,
  output logic             err_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [CNT_W-1:0] res_cnt_o,
  output logic             res_of_o,
  output logic [2:0]       state_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CLEAR   = 3'd1,
    COUNT   = 3'd2,
    CAPTURE = 3'd3,
    RESULT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIN_W-1:0]   timer_q, timer_d;
  logic [WIN_W-1:0]   len_q, len_d;
  logic               cont_q, cont_d;
  logic               sticky_q, sticky_d;

  logic               clr_d, en_d, busy_d, err_d, valid_d;
  logic [CNT_W-1:0]   res_cnt_d;
  logic               res_of_d;

  // Overflow-stop condition: only active in builds with early-stop enabled.
  logic               ovf_stop;
`ifdef CNT_WINDOW_OVF_STOP_EN
  assign ovf_stop = of_i;
`else
  assign ovf_stop = 1'b0;
`endif

  assign state_o = state_q;

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      len_q       <= '0;
      cont_q      <= 1'b0;
      sticky_q    <= 1'b0;
      cnt_clr_o   <= 1'b0;
      cnt_en_o    <= 1'b0;
      busy_o      <= 1'b0;
      err_o       <= 1'b0;
      res_valid_o <= 1'b0;
      res_cnt_o   <= '0;
      res_of_o    <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      len_q       <= len_d;
      cont_q      <= cont_d;
      sticky_q    <= sticky_d;
      cnt_clr_o   <= clr_d;
      cnt_en_o    <= en_d;
      busy_o      <= busy_d;
      err_o       <= err_d;
      res_valid_o <= valid_d;
      res_cnt_o   <= res_cnt_d;
      res_of_o    <= res_of_d;
    end
  end

  // Next-state logic; outputs are computed for the state being entered so
  // that every output is a flop aligned with state_q. abort_i wins over all
  // other transitions outside IDLE.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    len_d     = len_q;
    cont_d    = cont_q;
    sticky_d  = sticky_q;
    clr_d     = 1'b0;
    en_d      = 1'b0;
    err_d     = 1'b0;
    valid_d   = 1'b0;
    res_cnt_d = res_cnt_o;
    res_of_d  = res_of_o;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (win_len_i != '0) begin
            len_d   = win_len_i;
            cont_d  = cont_i;
            state_d = CLEAR;
            clr_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      CLEAR: begin
        if (abort_i) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else begin
          timer_d  = len_q;
          sticky_d = 1'b0;
          state_d  = COUNT;
          en_d     = 1'b1;
        end
      end

      COUNT: begin
        if (abort_i) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else begin
          timer_d = timer_q - WIN_W'(1);
          if (of_i) begin
            sticky_d = 1'b1;
          end
          // Timer holds the cycles left including this one, so leaving at 1
          // gives exactly win_len enabled cycles.
          if (timer_q == WIN_W'(1) || ovf_stop) begin
            state_d = CAPTURE;
          end else begin
            en_d = 1'b1;
          end
        end
      end

      CAPTURE: begin
        if (abort_i) begin
          state_d = IDLE;
          clr_d   = 1'b1;
        end else begin
          res_cnt_d = cnt_i;
          res_of_d  = sticky_q | of_i;
          valid_d   = 1'b1;
          state_d   = RESULT;
        end
      end

      RESULT: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (res_ready_i) begin
          if (cont_q) begin
            state_d = CLEAR;
            clr_d   = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

endmodule

// File: tb/tb_cnt_window_ctrl.sv
// Bench for cnt_window_ctrl: models the 8-bit event counter around the DUT,
// drives windows with directed and random num_i patterns, and checks the
// captured results against counts computed directly from the pattern.
module tb_cnt_window_ctrl;

  localparam int WIN_W = 16;
  localparam int CNT_W = 8;
  localparam int MAXL  = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start_i = 1'b0;
  logic             cont_i = 1'b0;
  logic             abort_i = 1'b0;
  logic [WIN_W-1:0] win_len_i = '0;
  logic             cnt_clr_o;
  logic             cnt_en_o;
  logic [CNT_W-1:0] cnt_i;
  logic             of_i;
  logic             busy_o;
  logic             err_o;
  logic             res_valid_o;
  logic             res_ready_i = 1'b0;
  logic [CNT_W-1:0] res_cnt_o;
  logic             res_of_o;
  logic [2:0]       state_o;

  int checks = 0;
  int failures = 0;

  // Counter model: +1 on each enabled cycle with num_i=1, cleared by
  // cnt_clr_o, of_i is the carry out of a 255 -> 0 wrap. Not reset by rst.
  logic             num_i = 1'b1;
  logic [CNT_W-1:0] mcnt = '0;
  bit               pat [MAXL];
  logic [CNT_W:0]   exp_q [$];

  assign cnt_i = mcnt;
  assign of_i  = cnt_en_o & num_i & (mcnt == 8'hFF);

  cnt_window_ctrl #(.WIN_W(WIN_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start_i     (start_i),
    .cont_i      (cont_i),
    .abort_i     (abort_i),
    .win_len_i   (win_len_i),
    .cnt_clr_o   (cnt_clr_o),
    .cnt_en_o    (cnt_en_o),
    .cnt_i       (cnt_i),
    .of_i        (of_i),
    .busy_o      (busy_o),
    .err_o       (err_o),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_cnt_o   (res_cnt_o),
    .res_of_o    (res_of_o),
    .state_o     (state_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Counter model register.
  always @(posedge clk) begin
    if (cnt_clr_o) mcnt <= '0;
    else if (cnt_en_o && num_i) mcnt <= mcnt + 8'd1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: sim time expired before tests completed");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // ---------------- reference model ----------------
  // Expected result from the num_i pattern of a window of length L: count
  // the events, stopping at the 256th one when early stop is built in.
  function automatic void ref_result(input int L, output logic [CNT_W-1:0] c,
                                     output logic o, output int k_en);
    int ones;
    ones = 0;
    k_en = L;
    for (int k = 0; k < L; k++) begin
      if (pat[k]) begin
        ones++;
`ifdef CNT_WINDOW_OVF_STOP_EN
        if (ones == 256) begin
          k_en = k + 1;
          break;
        end
`endif
      end
    end
    c = CNT_W'(ones % 256);
    o = (ones >= 256);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_pat(input int L, input bit rnd);
    for (int k = 0; k < MAXL; k++) pat[k] = rnd ? bit'($urandom_range(0, 1)) : 1'b1;
    if (L > MAXL) $display("note: window longer than pattern store");
  endtask

  // Presents a start for one cycle; returns just after the accepting edge.
  // Length/mode are scrambled afterwards since they must already be latched.
  task automatic start_run(input int L, input bit cont);
    start_i   = 1'b1;
    win_len_i = WIN_W'(L);
    cont_i    = cont;
    tick();
    start_i   = 1'b0;
    win_len_i = WIN_W'($urandom_range(0, 65535));
    cont_i    = 1'(~cont);
  endtask

  // Starting just after the edge that enters CLEAR, drives num_i from the
  // pattern (window cycle k uses pat[k]) and returns the number of edges
  // until res_valid_o is seen (0 on timeout).
  task automatic run_until_valid(input int L, input bit rnd, input int limit,
                                 output int lat);
    lat = 0;
    num_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    for (int n = 1; n <= limit && lat == 0; n++) begin
      tick();
      if (res_valid_o) lat = n;
      else if (n - 1 < L) num_i = pat[n-1];
      else num_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({cnt_clr_o, cnt_en_o, busy_o, err_o, res_valid_o, res_of_o, res_cnt_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got clr=%b en=%b busy=%b err=%b valid=%b of=%b cnt=%0d want all 0",
               cnt_clr_o, cnt_en_o, busy_o, err_o, res_valid_o, res_of_o, res_cnt_o);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) tick();
    checks++;
    if ({cnt_clr_o, cnt_en_o, busy_o, res_valid_o} !== 4'b0) begin
      failures++;
      $display("FAIL idle_quiet: got clr=%b en=%b busy=%b valid=%b want 0",
               cnt_clr_o, cnt_en_o, busy_o, res_valid_o);
    end
  endtask

  task automatic test_single_shot();
    logic [CNT_W-1:0] ec;
    logic eo;
    int k, lat;
    fill_pat(10, 1'b0);
    ref_result(10, ec, eo, k);
    res_ready_i = 1'b1;
    start_run(10, 1'b0);
    checks++;
    if (busy_o !== 1'b1 || cnt_clr_o !== 1'b1) begin
      failures++;
      $display("FAIL single_clear: got busy=%b clr=%b want 1 1", busy_o, cnt_clr_o);
    end
    run_until_valid(10, 1'b0, 100, lat);
    checks++;
    if (lat !== k + 2) begin
      failures++;
      $display("FAIL single_latency: got %0d edges want %0d", lat, k + 2);
    end
    checks++;
    if (res_cnt_o !== ec || res_of_o !== eo) begin
      failures++;
      $display("FAIL single_result: got cnt=%0d of=%b want cnt=%0d of=%b", res_cnt_o, res_of_o, ec, eo);
    end
    tick();
    checks++;
    if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL single_done: got valid=%b busy=%b want 0 0", res_valid_o, busy_o);
    end
  endtask

  task automatic test_overflow();
    logic [CNT_W-1:0] ec;
    logic eo;
    int k, lat;
    fill_pat(300, 1'b0);
    ref_result(300, ec, eo, k);
    res_ready_i = 1'b1;
    start_run(300, 1'b0);
    run_until_valid(300, 1'b0, 400, lat);
    checks++;
    if (lat !== k + 2) begin
      failures++;
      $display("FAIL ovf_latency: got %0d edges want %0d", lat, k + 2);
    end
    checks++;
    if (res_cnt_o !== ec || res_of_o !== eo) begin
      failures++;
      $display("FAIL ovf_result: got cnt=%0d of=%b want cnt=%0d of=%b", res_cnt_o, res_of_o, ec, eo);
    end
    tick();
    checks++;
    if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL ovf_done: got valid=%b busy=%b want 0 0", res_valid_o, busy_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [CNT_W-1:0] ec;
    logic eo;
    int k, lat;
    fill_pat(5, 1'b0);
    ref_result(5, ec, eo, k);
    res_ready_i = 1'b0;
    start_run(5, 1'b1);
    run_until_valid(5, 1'b0, 50, lat);
    checks++;
    if (lat !== k + 2 || res_cnt_o !== ec || res_of_o !== eo) begin
      failures++;
      $display("FAIL b2b_first: got lat=%0d cnt=%0d of=%b want lat=%0d cnt=%0d of=%b",
               lat, res_cnt_o, res_of_o, k + 2, ec, eo);
    end
    // Backpressure: result must hold; a start here must be ignored.
    for (int i = 0; i < 20; i++) begin
      start_i   = (i < 10);
      win_len_i = WIN_W'(3);
      tick();
      checks++;
      if (res_valid_o !== 1'b1 || res_cnt_o !== ec || res_of_o !== eo || cnt_en_o !== 1'b0) begin
        failures++;
        $display("FAIL b2b_hold[%0d]: got valid=%b cnt=%0d of=%b en=%b want 1 %0d %b 0",
                 i, res_valid_o, res_cnt_o, res_of_o, cnt_en_o, ec, eo);
      end
    end
    start_i = 1'b0;
    res_ready_i = 1'b1;
    tick();
    res_ready_i = 1'b0;
    checks++;
    if (res_valid_o !== 1'b0 || cnt_clr_o !== 1'b1 || busy_o !== 1'b1) begin
      failures++;
      $display("FAIL b2b_reclear: got valid=%b clr=%b busy=%b want 0 1 1", res_valid_o, cnt_clr_o, busy_o);
    end
    run_until_valid(5, 1'b0, 50, lat);
    checks++;
    if (lat !== k + 2 || res_cnt_o !== ec || res_of_o !== eo) begin
      failures++;
      $display("FAIL b2b_second: got lat=%0d cnt=%0d of=%b want lat=%0d cnt=%0d of=%b",
               lat, res_cnt_o, res_of_o, k + 2, ec, eo);
    end
    // Abort in RESULT discards the result and ends the continuous run.
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (res_valid_o !== 1'b0 || busy_o !== 1'b0 || cnt_clr_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_abort: got valid=%b busy=%b clr=%b want 0 0 0", res_valid_o, busy_o, cnt_clr_o);
    end
    repeat (3) tick();
    checks++;
    if (busy_o !== 1'b0 || cnt_en_o !== 1'b0) begin
      failures++;
      $display("FAIL b2b_stopped: got busy=%b en=%b want 0 0", busy_o, cnt_en_o);
    end
  endtask

  task automatic test_abort();
    bit seen_valid;
    res_ready_i = 1'b1;
    num_i = 1'b1;
    start_run(50, 1'b0);
    repeat (21) tick();
    checks++;
    if (cnt_en_o !== 1'b1 || mcnt !== 8'd20) begin
      failures++;
      $display("FAIL abort_pre: got en=%b cnt=%0d want 1 20", cnt_en_o, mcnt);
    end
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0 || cnt_clr_o !== 1'b1 || cnt_en_o !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle: got busy=%b clr=%b en=%b want 0 1 0", busy_o, cnt_clr_o, cnt_en_o);
    end
    tick();
    checks++;
    if (cnt_clr_o !== 1'b0 || mcnt !== 8'd0) begin
      failures++;
      $display("FAIL abort_clrpulse: got clr=%b cnt=%0d want 0 0", cnt_clr_o, mcnt);
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (res_valid_o || busy_o) seen_valid = 1'b1;
    end
    checks++;
    if (seen_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_noresult: got activity=%b want 0", seen_valid);
    end
  endtask

  task automatic test_reject();
    start_i   = 1'b1;
    win_len_i = '0;
    cont_i    = 1'b0;
    tick();
    start_i = 1'b0;
    checks++;
    if (err_o !== 1'b1 || busy_o !== 1'b0 || cnt_clr_o !== 1'b0) begin
      failures++;
      $display("FAIL reject_err: got err=%b busy=%b clr=%b want 1 0 0", err_o, busy_o, cnt_clr_o);
    end
    tick();
    checks++;
    if (err_o !== 1'b0 || busy_o !== 1'b0) begin
      failures++;
      $display("FAIL reject_pulse: got err=%b busy=%b want 0 0", err_o, busy_o);
    end
  endtask

  task automatic test_reset_mid_run();
    logic [CNT_W-1:0] ec;
    logic eo;
    int k, lat;
    fill_pat(100, 1'b0);
    res_ready_i = 1'b1;
    start_run(100, 1'b0);
    repeat (30) tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({cnt_clr_o, cnt_en_o, busy_o, err_o, res_valid_o, res_of_o, res_cnt_o} !== '0) begin
      failures++;
      $display("FAIL rst_mid: got clr=%b en=%b busy=%b err=%b valid=%b of=%b cnt=%0d want all 0",
               cnt_clr_o, cnt_en_o, busy_o, err_o, res_valid_o, res_of_o, res_cnt_o);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
    fill_pat(10, 1'b0);
    ref_result(10, ec, eo, k);
    start_run(10, 1'b0);
    run_until_valid(10, 1'b0, 100, lat);
    checks++;
    if (lat !== k + 2 || res_cnt_o !== ec || res_of_o !== eo) begin
      failures++;
      $display("FAIL rst_rerun: got lat=%0d cnt=%0d of=%b want lat=%0d cnt=%0d of=%b",
               lat, res_cnt_o, res_of_o, k + 2, ec, eo);
    end
    tick();
  endtask

  task automatic test_random();
    logic [CNT_W-1:0] ec;
    logic eo;
    logic [CNT_W:0] exp_v;
    int k, lat, L, d;
    for (int it = 0; it < 10; it++) begin
      L = (it == 9) ? 600 : $urandom_range(1, 40);
      d = $urandom_range(0, 3);
      fill_pat(L, 1'b1);
      ref_result(L, ec, eo, k);
      exp_q.push_back({eo, ec});
      res_ready_i = 1'b0;
      start_run(L, 1'b0);
      run_until_valid(L, 1'b1, L + 20, lat);
      checks++;
      if (lat !== k + 2) begin
        failures++;
        $display("FAIL rand_latency[%0d]: got %0d edges want %0d (L=%0d)", it, lat, k + 2, L);
      end
      for (int j = 0; j < d; j++) begin
        tick();
        checks++;
        if (res_valid_o !== 1'b1) begin
          failures++;
          $display("FAIL rand_hold[%0d]: got valid=%b want 1", it, res_valid_o);
        end
      end
      exp_v = exp_q.pop_front();
      checks++;
      if ({res_of_o, res_cnt_o} !== exp_v) begin
        failures++;
        $display("FAIL rand_result[%0d]: got of=%b cnt=%0d want of=%b cnt=%0d (L=%0d)",
                 it, res_of_o, res_cnt_o, exp_v[CNT_W], exp_v[CNT_W-1:0], L);
      end
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      checks++;
      if (res_valid_o !== 1'b0 || busy_o !== 1'b0) begin
        failures++;
        $display("FAIL rand_done[%0d]: got valid=%b busy=%b want 0 0", it, res_valid_o, busy_o);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_shot();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_reject();
    test_reset_mid_run();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
